// File: rtl/esfa_test_sequencer.sv
// On-chip self-test sequencer: fetches instructions from a block ROM, drives the
// ESFA write/query ports and scores query results against expected values.
module esfa_test_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int IDX_W        = 8,
  parameter int VAL_W        = 8,
  parameter int SEL_W        = 8,
  parameter int ROM_LAT      = 1,
  parameter int DUT_LAT      = 1,
  parameter int FAIL_W       = 8,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ADDR_W-1:0]                  last_addr,
  output logic [ADDR_W-1:0]                  rom_addr,
  input  logic [3+IDX_W+2*VAL_W+SEL_W-1:0]   rom_data,
  output logic                               dut_will_write,
  output logic [IDX_W-1:0]                   dut_new_index,
  output logic [VAL_W-1:0]                   dut_new_value,
  output logic [VAL_W-1:0]                   dut_metadata,
  output logic                               dut_is_metadata,
  output logic [SEL_W-1:0]                   dut_selector,
  input  logic                               dut_result_bool,
  input  logic [VAL_W-1:0]                   dut_result_value,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic [FAIL_W-1:0]                  fail_count,
  output logic [ADDR_W-1:0]                  first_fail_addr
);

  localparam int INSTR_W  = 3 + IDX_W + 2*VAL_W + SEL_W;
  localparam int IDX_LSB  = 2;
  localparam int VAL_LSB  = IDX_LSB + IDX_W;
  localparam int META_LSB = VAL_LSB + VAL_W;
  localparam int ISM_BIT  = META_LSB + VAL_W;
  localparam int SEL_LSB  = ISM_BIT + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CHECK = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]         state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  last_q;
  logic [15:0]        cnt;
  logic [1:0]         ir_op;

  logic [INSTR_W-1:0] instr;
  logic [1:0]         op_in;
  logic               cmp_last;
  logic               mismatch;
  logic               at_end;
  logic [FAIL_W-1:0]  fail_nx;

  assign instr    = rom_data;
  assign op_in    = instr[1:0];
  assign rom_addr = pc;

  always_comb begin
    cmp_last = (state == S_WAIT) && (cnt == 16'(DUT_LAT - 1));
    mismatch = (dut_result_bool != dut_is_metadata) || (dut_result_value != dut_metadata);
    at_end   = (pc == last_q);
    fail_nx  = (cmp_last && mismatch) ? sat_inc(fail_count) : fail_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      pc              <= '0;
      last_q          <= '0;
      cnt             <= '0;
      ir_op           <= OP_NOP;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      dut_will_write  <= 1'b0;
      dut_new_index   <= '0;
      dut_new_value   <= '0;
      dut_metadata    <= '0;
      dut_is_metadata <= 1'b0;
      dut_selector    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc              <= '0;
            last_q          <= last_addr;
            cnt             <= '0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            state           <= S_FETCH;
          end
        end
        // rom_addr is held on pc until the ROM pipeline has produced the word
        S_FETCH: begin
          if (cnt == 16'(ROM_LAT - 1)) begin
            cnt   <= '0;
            state <= S_LOAD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_LOAD: begin
          ir_op <= op_in;
          if (op_in == OP_HALT) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_nx == '0);
          end else begin
            dut_new_index   <= instr[IDX_LSB +: IDX_W];
            dut_new_value   <= instr[VAL_LSB +: VAL_W];
            dut_metadata    <= instr[META_LSB +: VAL_W];
            dut_is_metadata <= instr[ISM_BIT];
            dut_selector    <= instr[SEL_LSB +: SEL_W];
            dut_will_write  <= (op_in == OP_WRITE);
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          dut_will_write <= 1'b0;
          if (ir_op == OP_CHECK) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else if (at_end) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_nx == '0);
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        // Result is scored only on the final wait cycle, DUT_LAT after issue
        S_WAIT: begin
          if (cmp_last) begin
            cnt        <= '0;
            fail_count <= fail_nx;
            if (mismatch && (fail_count == '0))
              first_fail_addr <= pc;
            if ((mismatch && STOP_ON_FAIL) || at_end) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_nx == '0);
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
